dmem_unit: RTL and testbench

Data-memory responder for the RV64 datapath: consumes the store/load controls from the instruction decoder (`mem_wr`, `ld`, `wmask`) plus ALU address and rs2 data, and performs byte-masked stores and 64-bit loads on a single-port synchronous RAM. Accesses that cross an 8-byte word boundary are split into two RAM cycles by a small FSM, and `stall` freezes the core meanwhile. Sits between the ALU result and the writeback mux (`memtoreg = 01`).

---
 rtl/dmem_pkg.sv | 19 +
 rtl/sp_ram_be.sv | 32 +++
 rtl/dmem_unit.sv | 158 +++++++++++++++
 tb/tb_dmem_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_t     - FSM states of dmem_unit
//   WORD_BYTES  - bytes per RAM word
//   WM_SD/SW/SH - LSB-aligned store byte masks, also used by the decoder
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WR_HI = 2'd1,
      S_RD_LO = 2'd2,
      S_RD_HI = 2'd3
   } state_t;

   localparam int         WORD_BYTES = 8;
   localparam logic [7:0] WM_SD      = 8'hFF;
   localparam logic [7:0] WM_SW      = 8'h0F;
   localparam logic [7:0] WM_SH      = 8'h03;

endpackage

// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port synchronous RAM, DEPTH x 64 bits, byte enables.
//   clk  - clock
//   we   - write enable
//   be   - byte-lane enables (bit b covers din[8b+7:8b])
//   idx  - word index
//   din  - write data
//   dout - read data, one cycle after idx is presented; read-first, so a
//          write and read of the same word in one cycle returns old data
module sp_ram_be
   import dmem_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [7:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [63:0]      din,
   output logic [63:0]      dout
);

   logic [63:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
         if (we && be[b]) mem[idx][8*b +: 8] <= din[8*b +: 8];
      end
      dout <= mem[idx];
   end

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: data-memory responder for the RV64 datapath.
//   clk, rst - clock, synchronous active-high reset
//   mem_wr   - store request        ld     - load request (store wins)
//   wmask    - store lane mask (LSB-aligned)
//   addr     - byte address         wdata  - store data (LSB-aligned)
//   rdata    - load result, valid while rvalid and held afterwards
//   rvalid   - load completes this cycle
//   stall    - requester holds its inputs and retries next cycle
// Accesses crossing an 8-byte boundary take a second RAM cycle.
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_wr,
   input  logic        ld,
   input  logic [7:0]  wmask,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic [63:0] rdata,
   output logic        rvalid,
   output logic        stall
);

   function automatic logic [15:0] lane_mask(input logic [7:0] m, input logic [2:0] o);
      return {8'b0, m} << o;
   endfunction

   function automatic logic [127:0] lane_data(input logic [63:0] d, input logic [2:0] o);
      return {64'b0, d} << {o, 3'b000};
   endfunction

   function automatic logic [63:0] merge_words(input logic [63:0] hi, input logic [63:0] lo,
                                               input logic [2:0] o);
      logic [127:0] t;
      t = {hi, lo} >> {o, 3'b000};
      return t[63:0];
   endfunction

   state_t           state, state_nxt;
   logic [2:0]       off;
   logic [IDX_W-1:0] idx;
   logic [15:0]      m16;
   logic [127:0]     d128;
   logic             split_wr;

   // request captured in IDLE, used by the second cycle of a split access
   logic [2:0]       off_r;
   logic [IDX_W-1:0] idx_hi_r;
   logic [7:0]       mhi_r;
   logic [63:0]      dhi_r;
   logic [63:0]      lo_r;
   logic [63:0]      rdata_r;

   logic             ram_we;
   logic [7:0]       ram_be;
   logic [IDX_W-1:0] ram_idx;
   logic [63:0]      ram_din, ram_dout;
   logic [63:0]      load_word;
   logic             unused_addr;

   assign off         = addr[2:0];
   assign idx         = addr[3 +: IDX_W];
   assign unused_addr = ^addr[63:3+IDX_W];
   assign m16         = lane_mask(wmask, off);
   assign d128        = lane_data(wdata, off);
   assign split_wr    = (m16[15:8] != 8'h00);

   assign load_word = (state == S_RD_HI) ? merge_words(ram_dout, lo_r, off_r) : ram_dout;
   assign rdata     = rvalid ? load_word : rdata_r;

   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      ram_be    = m16[7:0];
      ram_idx   = idx;
      ram_din   = d128[63:0];
      stall     = 1'b0;
      rvalid    = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_wr) begin
               ram_we = (m16[7:0] != 8'h00);
               if (split_wr) begin
                  stall     = 1'b1;
                  state_nxt = S_WR_HI;
               end
            end else if (ld) begin
               stall     = 1'b1;
               state_nxt = S_RD_LO;
            end
         end
         S_WR_HI: begin
            ram_we    = 1'b1;
            ram_be    = mhi_r;
            ram_idx   = idx_hi_r;
            ram_din   = dhi_r;
            state_nxt = S_IDLE;
         end
         S_RD_LO: begin
            // the w+1 read is only consumed when the load is misaligned
            ram_idx = idx_hi_r;
            if (off_r == 3'd0) begin
               rvalid    = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               stall     = 1'b1;
               state_nxt = S_RD_HI;
            end
         end
         S_RD_HI: begin
            rvalid    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // reset drops any pending high-half write and load completion
      if (rst) begin
         ram_we    = 1'b0;
         rvalid    = 1'b0;
         stall     = 1'b0;
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         rdata_r <= 64'h0;
      end else begin
         state <= state_nxt;
         if (rvalid) rdata_r <= load_word;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE) begin
         off_r    <= off;
         idx_hi_r <= idx + IDX_W'(1);
         mhi_r    <= m16[15:8];
         dhi_r    <= d128[127:64];
      end
      if (state == S_RD_LO) lo_r <= ram_dout;
   end

   sp_ram_be #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .be   (ram_be),
      .idx  (ram_idx),
      .din  (ram_din),
      .dout (ram_dout)
   );

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed bench for dmem_unit with a byte-addressed
// reference model and a scoreboard queue of expected load results.
module tb_dmem_unit;
   import dmem_pkg::*;

   localparam int DEPTH = 512;
   localparam int MEMB  = 8 * DEPTH;
   localparam int ABITS = $clog2(MEMB);

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_wr;
   logic        ld;
   logic [7:0]  wmask;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        rvalid;
   logic        stall;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  model [MEMB];
   logic [63:0] exp_q [$];

   dmem_unit #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .mem_wr (mem_wr),
      .ld     (ld),
      .wmask  (wmask),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .rvalid (rvalid),
      .stall  (stall)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model_read(input logic [63:0] a);
      logic [63:0] r;
      int base;
      base = int'(a[ABITS-1:0]);
      for (int i = 0; i < 8; i++) r[8*i +: 8] = model[(base + i) % MEMB];
      return r;
   endfunction

   task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
      int base;
      base = int'(a[ABITS-1:0]);
      for (int i = 0; i < 8; i++) if (m[i]) model[(base + i) % MEMB] = d[8*i +: 8];
   endtask

   task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                           input logic with_ld);
      logic split;
      split = 1'b0;
      for (int i = 0; i < 8; i++) if (m[i] && (int'(a[2:0]) + i >= 8)) split = 1'b1;
      mem_wr = 1'b1; ld = with_ld; wmask = m; addr = a; wdata = d;
      #1;
      chk_bit("st_req_stall", stall, split);
      model_write(a, d, m);
      cyc();
      if (split) begin
         chk_bit("st_wrhi_stall", stall, 1'b0);
         cyc();
      end
      mem_wr = 1'b0; ld = 1'b0; wmask = 8'h00;
      #1;
      chk_bit("st_no_rvalid", rvalid, 1'b0);
   endtask

   task automatic do_load(input logic [63:0] a);
      int   lat;
      int   want;
      logic seen;
      logic [63:0] expv;
      want = (a[2:0] == 3'd0) ? 1 : 2;
      exp_q.push_back(model_read(a));
      ld = 1'b1; addr = a;
      #1;
      chk_bit("ld_req_stall", stall, 1'b1);
      seen = 1'b0;
      lat  = 0;
      for (int k = 1; k <= 4 && !seen; k++) begin
         cyc();
         if (rvalid) begin
            seen = 1'b1;
            lat  = k;
         end else begin
            chk_bit("ld_wait_stall", stall, 1'b1);
         end
      end
      if (!seen) begin
         chk_bit("ld_rvalid_timeout", rvalid, 1'b1);
         void'(exp_q.pop_front());
      end else begin
         chk("ld_latency", 64'(lat), 64'(want));
         chk_bit("ld_done_stall", stall, 1'b0);
         expv = exp_q.pop_front();
         chk("ld_rdata", rdata, expv);
         ld = 1'b0;
         cyc();
         chk("ld_rdata_hold", rdata, expv);
         chk_bit("ld_rvalid_pulse", rvalid, 1'b0);
      end
      ld = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mem_wr = 1'b0; ld = 1'b0; wmask = 8'h00; addr = 64'h0; wdata = 64'h0;
      for (int i = 0; i < MEMB; i++) model[i] = 8'h00;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      chk_bit("rst_stall", stall, 1'b0);
      chk_bit("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", rdata, 64'h0);

      // zero every word so the model and RAM start identical
      for (int i = 0; i < DEPTH; i++) begin
         mem_wr = 1'b1; wmask = WM_SD; addr = 64'(8 * i); wdata = 64'h0;
         cyc();
      end
      mem_wr = 1'b0; wmask = 8'h00;
      cyc();

      // aligned sd / ld
      do_store(64'h10, 64'h1122334455667788, WM_SD, 1'b0);
      do_load(64'h10);
      chk("sd_const", rdata, 64'h1122334455667788);

      // sh into a zeroed word
      do_store(64'h22, 64'h000000000000BEEF, WM_SH, 1'b0);
      do_load(64'h20);
      chk("sh_const", rdata, 64'h00000000BEEF0000);

      // split sw across words 1 and 2
      do_store(64'h0E, 64'h00000000AABBCCDD, WM_SW, 1'b0);
      do_load(64'h08);
      chk("sw_w1_hi", {48'h0, rdata[63:48]}, 64'hCCDD);
      do_load(64'h10);
      chk("sw_w2_lo", {48'h0, rdata[15:0]}, 64'hAABB);
      do_load(64'h0E);
      chk("sw_split_ld", {32'h0, rdata[31:0]}, 64'hAABBCCDD);

      // wrap from the last word to word 0, upper address bits ignored
      do_store(64'(8 * (DEPTH - 1)), 64'hA8A7A6A5A4A3A2A1, WM_SD, 1'b0);
      do_store(64'h0, 64'hB8B7B6B5B4B3B2B1, WM_SD, 1'b0);
      do_load(64'hFFFF_0000_0000_0000 | 64'(MEMB - 4));
      do_store(64'(MEMB - 2), 64'h00000000CAFEF00D, WM_SW, 1'b0);
      do_load(64'(MEMB - 8));
      do_load(64'h0);

      // store and load together: store wins, no load completion
      do_store(64'h30, 64'h0123456789ABCDEF, WM_SD, 1'b1);
      cyc();
      chk_bit("both_no_rvalid", rvalid, 1'b0);
      do_load(64'h30);

      // empty mask: nothing written
      do_store(64'h30, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0);
      do_load(64'h30);

      // misaligned load into a word holding mixed data
      do_store(64'h53, 64'h00000000DEADBEEF, WM_SW, 1'b0);
      do_load(64'h51);

      // reset during WR_HI: low half kept, high half dropped
      mem_wr = 1'b1; wmask = WM_SD; addr = 64'h44; wdata = 64'h0102030405060708;
      #1;
      chk_bit("rstwr_req_stall", stall, 1'b1);
      cyc();
      rst = 1'b1;
      #1;
      chk_bit("rstwr_stall", stall, 1'b0);
      cyc();
      rst = 1'b0; mem_wr = 1'b0; wmask = 8'h00;
      for (int i = 0; i < 4; i++) model[68 + i] = wdata[8*i +: 8];
      #1;
      chk_bit("rstwr_after_stall", stall, 1'b0);
      chk_bit("rstwr_after_rvalid", rvalid, 1'b0);
      do_load(64'h40);
      chk("rstwr_w_const", rdata, 64'h0506070800000000);
      do_load(64'h48);
      chk("rstwr_w1_const", rdata, 64'h0);

      // reset during RD_HI: completion suppressed, rdata cleared
      do_load(64'h10);
      ld = 1'b1; addr = 64'h0E;
      #1;
      cyc();
      chk_bit("rstrd_rdlo_stall", stall, 1'b1);
      cyc();
      rst = 1'b1;
      #1;
      chk_bit("rstrd_rvalid", rvalid, 1'b0);
      cyc();
      rst = 1'b0; ld = 1'b0;
      #1;
      chk_bit("rstrd_after_rvalid", rvalid, 1'b0);
      chk("rstrd_rdata", rdata, 64'h0);
      cyc();
      chk_bit("rstrd_idle_stall", stall, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
